mips_regfile: RTL and testbench

- 32 x WIDTH MIPS general-purpose register file, sitting directly downstream of the 5-to-32 write-address decoder.
- Write selection arrives as the decoder's one-hot vector `wsel`, not as a binary index.
- Provides two combinational read ports, an optional write-to-read bypass and a post-reset clearing sequencer.
- Checks every write's `wsel` for one-hot legality and flags decoder faults.

---
 rtl/mips_regfile.sv | 135 +++++++++++++
 tb/tb_mips_regfile.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile.sv
// 32 x WIDTH MIPS register file written through a one-hot decoder select.
// Two combinational read ports, optional same-cycle bypass, post-reset clear sweep and select fault tracking.
module mips_regfile #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [31:0]      wsel,
  input  logic [WIDTH-1:0] wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy,
  output logic             onehot_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic        onehot_err_q, onehot_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] regs_q [32];

  logic       ready;
  logic       wsel_onehot;
  logic [4:0] widx;
  logic       wr_legal;
  logic       wr_fault;
  logic       wr_en;

  assign ready = (state_q == ST_READY);

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign wsel_onehot = (wsel != 32'd0) && ((wsel & (wsel - 32'd1)) == 32'd0);

  always_comb begin
    widx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (wsel[i]) begin
        widx = widx | 5'(i);
      end
    end
  end

  assign wr_legal = ready && we && wsel_onehot;
  assign wr_fault = ready && we && !wsel_onehot;
  assign wr_en    = wr_legal && (widx != 5'd0);

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    onehot_err_d = onehot_err_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (wr_fault) begin
          onehot_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= 5'd1;
      onehot_err_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      onehot_err_q <= onehot_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Contents survive the reset edge; the clear sweep zeroes them afterwards. Entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_CLEAR) begin
        regs_q[clr_idx_q] <= '0;
      end else if (wr_en) begin
        regs_q[widx] <= wd;
      end
    end
  end

  always_comb begin
    rd1 = '0;
    if (ready && (ra1 != 5'd0)) begin
      if ((BYPASS != 0) && wr_en && (widx == ra1)) begin
        rd1 = wd;
      end else begin
        rd1 = regs_q[ra1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (ready && (ra2 != 5'd0)) begin
      if ((BYPASS != 0) && wr_en && (widx == ra2)) begin
        rd2 = wd;
      end else begin
        rd2 = regs_q[ra2];
      end
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign onehot_err = onehot_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile (WIDTH=32, BYPASS=1).
module tb_mips_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] wsel;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy;
  logic        onehot_err;
  logic [7:0]  err_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  mips_regfile #(.WIDTH(32), .BYPASS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .wsel       (wsel),
    .wd         (wd),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .busy       (busy),
    .onehot_err (onehot_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-20s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Counts rising edges until busy drops, bounded at 40.
  task automatic count_clear(output int edges);
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      edges = n;
      if (!busy) break;
    end
  endtask

  task automatic write_reg(input int idx, input logic [31:0] data);
    we   = 1'b1;
    wsel = 32'd1 << idx;
    wd   = data;
    tick();
    we   = 1'b0;
    wsel = 32'd0;
  endtask

  int edges;

  initial begin
    rst = 1'b0; we = 1'b0; wsel = 32'd0; wd = 32'd0; ra1 = 5'd0; ra2 = 5'd0;

    // Reset for two edges
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_onehot_err", {31'd0, onehot_err}, 32'd0);
    check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Write attempt during the clear sweep must be ignored
    rst = 1'b1;
    we = 1'b1; wsel = 32'h8000_0000; wd = 32'hA5A5_A5A5; ra1 = 5'd31; ra2 = 5'd31;
    #1;
    check("clear_rd1_zero", rd1, 32'd0);
    count_clear(edges);
    we = 1'b0; wsel = 32'd0;
    check("clear_edge_count", 32'(edges), 32'd31);
    #1;
    check("ready_onehot_err", {31'd0, onehot_err}, 32'd0);
    check("ready_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("reg31_after_clear", rd1, 32'd0);
    for (int a = 1; a < 31; a++) begin
      ra1 = 5'(a);
      #1;
      check($sformatf("clear_reg%0d", a), rd1, 32'd0);
    end

    // Bypass on both ports, then persistence
    we = 1'b1; wsel = 32'h0000_0020; wd = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("bypass_rd1", rd1, 32'hDEAD_BEEF);
    check("bypass_rd2", rd2, 32'hDEAD_BEEF);
    tick();
    we = 1'b0; wsel = 32'd0; wd = 32'd0;
    #1;
    check("reg5_after_edge", rd1, 32'hDEAD_BEEF);

    // Register 0 write dropped silently
    we = 1'b1; wsel = 32'h0000_0001; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
    #1;
    check("r0_before_edge", rd1, 32'd0);
    tick();
    we = 1'b0; wsel = 32'd0;
    #1;
    check("r0_after_edge", rd1, 32'd0);
    check("r0_no_err", {31'd0, onehot_err}, 32'd0);
    check("r0_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Consecutive writes to one register: last wins
    we = 1'b1; wsel = 32'h0000_0080; wd = 32'h0000_1111;
    tick();
    wd = 32'h0000_2222;
    tick();
    we = 1'b0; wsel = 32'd0;
    ra1 = 5'd7; ra2 = 5'd7;
    #1;
    check("reg7_last_wins_rd1", rd1, 32'h0000_2222);
    check("reg7_last_wins_rd2", rd2, 32'h0000_2222);

    // Illegal two-hot select
    write_reg(1, 32'h0000_0011);
    write_reg(2, 32'h0000_0022);
    we = 1'b1; wsel = 32'h0000_0006; wd = 32'h0000_1234; ra1 = 5'd1; ra2 = 5'd2;
    #1;
    check("illegal_no_bypass", rd1, 32'h0000_0011);
    tick();
    we = 1'b0; wsel = 32'd0;
    #1;
    check("illegal_reg1", rd1, 32'h0000_0011);
    check("illegal_reg2", rd2, 32'h0000_0022);
    check("illegal_onehot_err", {31'd0, onehot_err}, 32'd1);
    check("illegal_err_cnt", {24'd0, err_cnt}, 32'd1);

    // 300 more illegal (zero) selects saturate the counter
    we = 1'b1; wsel = 32'd0; wd = 32'hFFFF_0000;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 252) check("err_cnt_254", {24'd0, err_cnt}, 32'd254);
    end
    we = 1'b0;
    #1;
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
    check("onehot_err_sticky", {31'd0, onehot_err}, 32'd1);
    check("zero_sel_reg1", rd1, 32'h0000_0011);

    // Reset in the middle of a clear sweep restarts it
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("mid_clear_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    tick();
    check("rereset_busy", {31'd0, busy}, 32'd1);
    check("rereset_onehot_err", {31'd0, onehot_err}, 32'd0);
    check("rereset_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b1;
    count_clear(edges);
    check("restart_edge_count", 32'(edges), 32'd31);
    ra1 = 5'd5; ra2 = 5'd7;
    #1;
    check("reg5_cleared", rd1, 32'd0);
    check("reg7_cleared", rd2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
